mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 79 +++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage with 32x8 data RAM, registered write-back and RUN/HALTED FSM.
// Optional store counter output store_cnt when MEM_STORE_CNT_EN is defined.
module mem_stage (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_alu_result,
  input  logic       in_reg_write,
  input  logic       in_mem_write,
  input  logic [4:0] in_dest,
  input  logic [2:0] in_opcode,
  input  logic       in_halt,
  output logic [7:0] wb_data,
  output logic [4:0] wb_dest,
  output logic       wb_reg_write,
  output logic [2:0] wb_opcode,
  output logic       halted,
  output logic [7:0] fwd_data
`ifdef MEM_STORE_CNT_EN
  ,
  output logic [7:0] store_cnt
`endif
);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state_q, state_d;
  logic [31:0][7:0] mem_q;
  logic [7:0] wb_data_q, wb_data_d, rd_data;
  logic [4:0] wb_dest_q, wb_dest_d;
  logic [2:0] wb_opcode_q, wb_opcode_d;
  logic wb_rw_q, wb_rw_d, halt_req, we;
  assign halt_req = in_halt || in_opcode == 3'b111;
  assign we = state_q == RUN && in_opcode == 3'b011 && in_mem_write;
  assign rd_data = mem_q[in_alu_result[4:0]];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      mem_q       <= '0;
      wb_data_q   <= '0;
      wb_dest_q   <= '0;
      wb_opcode_q <= '0;
      wb_rw_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wb_data_q   <= wb_data_d;
      wb_dest_q   <= wb_dest_d;
      wb_opcode_q <= wb_opcode_d;
      wb_rw_q     <= wb_rw_d;
      if (we) mem_q[in_dest] <= in_alu_result;
    end
  end
  // HALTED holds every field except the write enable, which stays low
  always_comb begin
    state_d     = state_q;
    wb_data_d   = wb_data_q;
    wb_dest_d   = wb_dest_q;
    wb_opcode_d = wb_opcode_q;
    wb_rw_d     = 1'b0;
    if (state_q == RUN) begin
      state_d     = halt_req ? HALTED : RUN;
      wb_dest_d   = in_dest;
      wb_opcode_d = halt_req ? 3'b111 : in_opcode;
      wb_rw_d     = !halt_req && in_reg_write && in_opcode != 3'b011;
      wb_data_d   = halt_req ? wb_data_q : (in_opcode == 3'b010 ? rd_data : in_alu_result);
    end
  end
`ifdef MEM_STORE_CNT_EN
  logic [7:0] cnt_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else if (we && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
  end
  assign store_cnt = cnt_q;
`endif
  assign wb_data      = wb_data_q;
  assign fwd_data     = wb_data_q;
  assign wb_dest      = wb_dest_q;
  assign wb_opcode    = wb_opcode_q;
  assign wb_reg_write = wb_rw_q;
  assign halted       = state_q == HALTED;
endmodule
